// File: rtl/alu.sv
// 32-bit integer ALU with a registered result: one op per clock, one-cycle latency.
// Define ALU_DIV_EN to build the divider. Without it, arithmetic op 011 returns 0.
module alu (
  output logic [31:0] answer,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        A_or_L,
  input  logic        S_or_U,
  input  logic [2:0]  OpCode,
  input  logic        clk,
  input  logic        rst_n
);

  logic [31:0] answer_reg;
  logic [31:0] answer_next;
  logic [31:0] arith_next;
  logic [31:0] logic_next;
  logic [31:0] quot_next;
  logic [31:0] product;
  logic [4:0]  shamt;

  assign product = A * B;
  assign shamt   = B[4:0];

`ifdef ALU_DIV_EN
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] mag_q;
  logic        neg_q;

  // Signed divide goes through magnitudes so MIN / -1 wraps back to MIN.
  always_comb begin
    abs_a = (S_or_U && A[31]) ? (~A + 32'd1) : A;
    abs_b = (S_or_U && B[31]) ? (~B + 32'd1) : B;
    neg_q = S_or_U && (A[31] ^ B[31]);
    mag_q = (abs_b == 32'd0) ? 32'd0 : (abs_a / abs_b);
    if (B == 32'd0)
      quot_next = 32'hFFFF_FFFF;
    else if (neg_q)
      quot_next = ~mag_q + 32'd1;
    else
      quot_next = mag_q;
  end
`else
  logic unused_s_or_u;
  assign unused_s_or_u = S_or_U;
  assign quot_next     = 32'd0;
`endif

  always_comb begin
    arith_next = 32'd0;
    case (OpCode)
      3'b000:  arith_next = A + B;
      3'b001:  arith_next = A - B;
      3'b010:  arith_next = product;
      3'b011:  arith_next = quot_next;
      default: arith_next = 32'd0;
    endcase
  end

  always_comb begin
    logic_next = 32'd0;
    case (OpCode)
      3'b000:  logic_next = A & B;
      3'b001:  logic_next = A | B;
      3'b010:  logic_next = A ^ B;
      3'b011:  logic_next = ~A;
      3'b100:  logic_next = A << shamt;
      3'b101:  logic_next = A >> shamt;
      3'b110:  logic_next = $unsigned($signed(A) >>> shamt);
      default: logic_next = 32'd0;
    endcase
  end

  assign answer_next = A_or_L ? logic_next : arith_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      answer_reg <= 32'd0;
    else
      answer_reg <= answer_next;
  end

  assign answer = answer_reg;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: one task per feature, hand-computed expectations.
// Division expectations follow whether ALU_DIV_EN is defined for the build.
module tb_alu;

  logic [31:0] answer;
  logic [31:0] A;
  logic [31:0] B;
  logic        A_or_L;
  logic        S_or_U;
  logic [2:0]  OpCode;
  logic        clk;
  logic        rst_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        aol;
    logic        sou;
    logic [2:0]  op;
    logic [31:0] exp;
    string       name;
  } vec_t;

  alu dut (
    .answer(answer),
    .A(A),
    .B(B),
    .A_or_L(A_or_L),
    .S_or_U(S_or_U),
    .OpCode(OpCode),
    .clk(clk),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands, then sample 1 time unit after the next rising edge.
  task automatic apply(input vec_t v);
    A      = v.a;
    B      = v.b;
    A_or_L = v.aol;
    S_or_U = v.sou;
    OpCode = v.op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    A = 32'd64; B = 32'd16; A_or_L = 1'b0; S_or_U = 1'b0; OpCode = 3'b000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (answer !== 32'd0) begin
      bad++; $display("FAIL reset_async: answer=%h expected=%h", answer, 32'd0);
    end else $display("ok reset_async: answer=%h", answer);
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (answer !== 32'd0) begin
      bad++; $display("FAIL reset_held: answer=%h expected=%h", answer, 32'd0);
    end else $display("ok reset_held: answer=%h", answer);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (answer !== 32'd80) begin
      bad++; $display("FAIL reset_release: answer=%h expected=%h", answer, 32'd80);
    end else $display("ok reset_release: answer=%h", answer);
  endtask

  task automatic test_arith();
    vec_t v[8];
    v[0] = '{32'd64,        32'd16,        1'b0, 1'b0, 3'b000, 32'd80,          "add"};
    v[1] = '{32'd64,        32'd16,        1'b0, 1'b0, 3'b001, 32'd48,          "sub"};
    v[2] = '{32'd0,         32'd1,         1'b0, 1'b0, 3'b001, 32'hFFFF_FFFF,   "sub_wrap"};
    v[3] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 3'b000, 32'd0,           "add_wrap"};
    v[4] = '{32'd64,        32'd16,        1'b0, 1'b1, 3'b010, 32'd1024,        "mul_signed"};
    v[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b010, 32'd1,           "mul_low"};
    v[6] = '{32'h0001_0003, 32'h0001_0000, 1'b0, 1'b0, 3'b010, 32'h0003_0000,   "mul_trunc"};
    v[7] = '{32'd64,        32'd16,        1'b0, 1'b0, 3'b100, 32'd0,           "arith_1xx"};
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if (answer !== v[i].exp) begin
        bad++; $display("FAIL %s: answer=%h expected=%h", v[i].name, answer, v[i].exp);
      end else $display("ok %s: answer=%h", v[i].name, answer);
    end
  endtask

  task automatic test_div();
    vec_t v[7];
`ifdef ALU_DIV_EN
    v[0] = '{32'd64,        32'd16,        1'b0, 1'b0, 3'b011, 32'd4,           "div_u"};
    v[1] = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1, 3'b011, 32'hFFFF_FFFD,   "div_s_neg"};
    v[2] = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 3'b011, 32'h7FFF_FFFC,   "div_u_big"};
    v[3] = '{32'd64,        32'd0,         1'b0, 1'b1, 3'b011, 32'hFFFF_FFFF,   "div_s_zero"};
    v[4] = '{32'd64,        32'd0,         1'b0, 1'b0, 3'b011, 32'hFFFF_FFFF,   "div_u_zero"};
    v[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b011, 32'h8000_0000,   "div_s_min"};
    v[6] = '{32'd7,         32'hFFFF_FFFE, 1'b0, 1'b1, 3'b011, 32'hFFFF_FFFD,   "div_s_negb"};
`else
    v[0] = '{32'd64,        32'd16,        1'b0, 1'b0, 3'b011, 32'd0,           "div_off_u"};
    v[1] = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1, 3'b011, 32'd0,           "div_off_s"};
    v[2] = '{32'd64,        32'd0,         1'b0, 1'b0, 3'b011, 32'd0,           "div_off_zero"};
    v[3] = '{32'd5,         32'd3,         1'b0, 1'b0, 3'b000, 32'd8,           "add_after_div"};
    v[4] = '{32'd64,        32'd16,        1'b0, 1'b1, 3'b011, 32'd0,           "div_off_s2"};
    v[5] = '{32'd9,         32'd3,         1'b0, 1'b0, 3'b010, 32'd27,          "mul_after_div"};
    v[6] = '{32'd9,         32'd3,         1'b0, 1'b0, 3'b001, 32'd6,           "sub_after_div"};
`endif
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if (answer !== v[i].exp) begin
        bad++; $display("FAIL %s: answer=%h expected=%h", v[i].name, answer, v[i].exp);
      end else $display("ok %s: answer=%h", v[i].name, answer);
    end
  endtask

  task automatic test_logic();
    vec_t v[8];
    v[0] = '{32'd64,      32'd16,      1'b1, 1'b0, 3'b000, 32'd0,         "and"};
    v[1] = '{32'd64,      32'd16,      1'b1, 1'b0, 3'b001, 32'd80,        "or"};
    v[2] = '{32'd64,      32'd16,      1'b1, 1'b1, 3'b010, 32'd80,        "xor"};
    v[3] = '{32'd64,      32'd16,      1'b1, 1'b0, 3'b011, 32'hFFFF_FFBF, "not"};
    v[4] = '{32'h0000_F0F0, 32'h0000_FF00, 1'b1, 1'b1, 3'b000, 32'h0000_F000, "and_mask"};
    v[5] = '{32'h0000_00FF, 32'h0000_000F, 1'b1, 1'b0, 3'b010, 32'h0000_00F0, "xor_mask"};
    v[6] = '{32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b011, 32'hEDCB_A987, "not_ignore_b"};
    v[7] = '{32'd64,      32'd16,      1'b1, 1'b0, 3'b111, 32'd0,         "logic_111"};
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if (answer !== v[i].exp) begin
        bad++; $display("FAIL %s: answer=%h expected=%h", v[i].name, answer, v[i].exp);
      end else $display("ok %s: answer=%h", v[i].name, answer);
    end
  endtask

  task automatic test_shift();
    vec_t v[8];
    v[0] = '{32'h8000_0000, 32'd4,  1'b1, 1'b0, 3'b100, 32'd0,         "sll"};
    v[1] = '{32'h8000_0000, 32'd4,  1'b1, 1'b0, 3'b101, 32'h0800_0000, "srl"};
    v[2] = '{32'h8000_0000, 32'd4,  1'b1, 1'b0, 3'b110, 32'hF800_0000, "sra"};
    v[3] = '{32'd1,         32'd32, 1'b1, 1'b0, 3'b100, 32'd1,         "sll_b32"};
    v[4] = '{32'h4000_0000, 32'd36, 1'b1, 1'b0, 3'b110, 32'h0400_0000, "sra_pos"};
    v[5] = '{32'hA5A5_A5A5, 32'd0,  1'b1, 1'b1, 3'b101, 32'hA5A5_A5A5, "srl_zero"};
    v[6] = '{32'd3,         32'd31, 1'b1, 1'b0, 3'b100, 32'h8000_0000, "sll_31"};
    v[7] = '{32'h8000_0000, 32'd31, 1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, "sra_31"};
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if (answer !== v[i].exp) begin
        bad++; $display("FAIL %s: answer=%h expected=%h", v[i].name, answer, v[i].exp);
      end else $display("ok %s: answer=%h", v[i].name, answer);
    end
  endtask

  // Operands change every cycle; the output must lag by exactly one edge.
  task automatic test_back_to_back();
    vec_t v[4];
    v[0] = '{32'd10, 32'd20, 1'b0, 1'b0, 3'b000, 32'd30,  "b2b_add"};
    v[1] = '{32'd10, 32'd3,  1'b0, 1'b0, 3'b010, 32'd30,  "b2b_mul_same"};
    v[2] = '{32'd10, 32'd20, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFF6, "b2b_sub"};
    v[3] = '{32'hF,  32'h3,  1'b1, 1'b0, 3'b000, 32'd3,   "b2b_and"};
    foreach (v[i]) begin
      apply(v[i]);
      total++;
      if (answer !== v[i].exp) begin
        bad++; $display("FAIL %s: answer=%h expected=%h", v[i].name, answer, v[i].exp);
      end else $display("ok %s: answer=%h", v[i].name, answer);
    end
    A = 32'd1; B = 32'd1; A_or_L = 1'b0; OpCode = 3'b000;
    #2;
    total++;
    if (answer !== 32'd3) begin
      bad++; $display("FAIL b2b_hold: answer=%h expected=%h", answer, 32'd3);
    end else $display("ok b2b_hold: answer=%h", answer);
    @(posedge clk); #1;
    total++;
    if (answer !== 32'd2) begin
      bad++; $display("FAIL b2b_next: answer=%h expected=%h", answer, 32'd2);
    end else $display("ok b2b_next: answer=%h", answer);
  endtask

  task automatic test_reset_mid();
    A = 32'd7; B = 32'd6; A_or_L = 1'b0; S_or_U = 1'b0; OpCode = 3'b010;
    @(posedge clk); #1;
    total++;
    if (answer !== 32'd42) begin
      bad++; $display("FAIL mid_pre: answer=%h expected=%h", answer, 32'd42);
    end else $display("ok mid_pre: answer=%h", answer);
    A = 32'd100;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (answer !== 32'd0) begin
      bad++; $display("FAIL mid_reset: answer=%h expected=%h", answer, 32'd0);
    end else $display("ok mid_reset: answer=%h", answer);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (answer !== 32'd600) begin
      bad++; $display("FAIL mid_recover: answer=%h expected=%h", answer, 32'd600);
    end else $display("ok mid_recover: answer=%h", answer);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div();
    test_logic();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
